// File: rtl/cpu16_pkg.sv
// Shared types and sizes for the register-file read arbiter.
// Register width, register count, index width, requester id type and FSM states.
package cpu16_pkg;
  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;

  typedef logic [1:0] req_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } fsm_state_t;

  // Round-robin successor of a requester id, wrapping at n-1.
  function automatic req_id_t next_id(input req_id_t id, input int n);
    if (int'(id) == n - 1) return '0;
    return id + 2'd1;
  endfunction
endpackage

// File: rtl/rr_arb.sv
// Combinational arbiter: round-robin from ptr, or lowest-index-first when
// RF_READ_ARBITER_FIXED_PRIO_EN is defined (ptr is then ignored).
module rr_arb #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         id
);
  logic found;
  int   j;

`ifdef RF_READ_ARBITER_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef RF_READ_ARBITER_FIXED_PRIO_EN
      j = k;
`else
      // Search upward from ptr, wrapping past the top requester.
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
`endif
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        id       = j[1:0];
      end
    end
  end
endmodule

// File: rtl/rf_read_arbiter.sv
// Shares one register-file read port among NUM_REQ requesters through a
// single-entry output buffer. Build option: RF_READ_ARBITER_FIXED_PRIO_EN.
module rf_read_arbiter #(
  parameter int DATA_W   = cpu16_pkg::DATA_W,
  parameter int NUM_REGS = cpu16_pkg::NUM_REGS,
  parameter int NUM_REQ  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*4-1:0]       req_idx,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REGS*DATA_W-1:0] rf_flat,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  input  logic                       rsp_ready,
  output logic                       dbg_state
);
  import cpu16_pkg::*;

  // Handshake: a requester transfers when req_valid & req_ready at a rising
  // edge; the response transfers when rsp_valid & rsp_ready at a rising edge.
  fsm_state_t           state, state_nxt;
  logic [NUM_REQ-1:0]   grant;
  req_id_t              win_id, ptr;
  logic                 space, accept;
  logic [REG_IDX_W-1:0] sel_idx;
  logic [DATA_W-1:0]    sel_data;

  rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant),
    .id    (win_id)
  );

  assign space     = (state == EMPTY) || rsp_ready;
  assign accept    = rst_n && space && (|req_valid);
  assign req_ready = accept ? grant : '0;
  assign rsp_valid = (state == FULL);
  assign dbg_state = state;

  assign sel_idx  = req_idx[int'(win_id)*REG_IDX_W +: REG_IDX_W];
  assign sel_data = rf_flat[int'(sel_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_nxt = state;
    if (accept)                          state_nxt = FULL;
    else if (state == FULL && rsp_ready) state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // The buffer only loads on accept, so it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
    end else if (accept) begin
      rsp_data <= sel_data;
      rsp_id   <= win_id;
    end
  end

`ifdef RF_READ_ARBITER_FIXED_PRIO_EN
  assign ptr = '0;
`else
  req_id_t rr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n)      rr_ptr <= '0;
    else if (accept) rr_ptr <= next_id(win_id, NUM_REQ);
  end

  assign ptr = rr_ptr;
`endif
endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter: directed scenarios plus random traffic checked
// against a queue-based reference model (honours RF_READ_ARBITER_FIXED_PRIO_EN).
module tb_rf_read_arbiter;
  localparam int N  = 3;
  localparam int DW = 16;
  localparam int NR = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*4-1:0]    req_idx = '0;
  logic [N-1:0]      req_ready;
  logic [NR*DW-1:0]  rf_flat;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [DW-1:0]     rsp_data;
  logic              rsp_ready = 1'b0;
  logic              dbg_state;

  logic [DW-1:0]     rf_mem [NR];

  for (genvar r = 0; r < NR; r++) begin : g_rf
    assign rf_flat[r*DW +: DW] = rf_mem[r];
  end

  rf_read_arbiter #(.DATA_W(DW), .NUM_REGS(NR), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_idx   (req_idx),
    .req_ready (req_ready),
    .rf_flat   (rf_flat),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scoreboard: {id, data} of responses accepted but not yet drained.
  logic [DW+1:0] exp_q[$];
  int            m_ptr = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rule, or -1 when nobody requests.
  function automatic int model_winner(input logic [N-1:0] v);
    int start;
`ifdef RF_READ_ARBITER_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive, check against the model at the falling edge, then
  // advance the model at the rising edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*4-1:0] idx,
                       input logic rdy, input logic rstn, output logic [N-1:0] got);
    int           w;
    bit           space;
    logic [N-1:0] exp_rdy;
    logic [DW+1:0] head;
    logic [3:0]   ridx;
    req_valid = v;
    req_idx   = idx;
    rsp_ready = rdy;
    rst_n     = rstn;
    @(negedge clk);
    space   = (exp_q.size() == 0) || rdy;
    w       = model_winner(v);
    exp_rdy = (rstn && space && w >= 0) ? N'(1 << w) : '0;
    got     = req_ready;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    check_val("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
    check_val("dbg_state", 32'(dbg_state), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check_val("rsp_id", 32'(rsp_id), 32'(head[DW+1:DW]));
      check_val("rsp_data", 32'(rsp_data), 32'(head[DW-1:0]));
    end
    @(posedge clk);
    if (!rstn) begin
      exp_q.delete();
      m_ptr = 0;
    end else begin
      if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
      if (space && w >= 0) begin
        ridx = idx[w*4 +: 4];
        exp_q.push_back({2'(w), rf_mem[ridx]});
        m_ptr = (w + 1) % N;
      end
    end
    #1;
  endtask

  logic [N-1:0] got;
  logic [N-1:0] s2_exp [6];
  logic [N-1:0] s4_exp [4];
  logic [DW-1:0] v15, v0;

  initial begin
    for (int r = 0; r < NR; r++) rf_mem[r] = 16'($urandom);
`ifdef RF_READ_ARBITER_FIXED_PRIO_EN
    s2_exp = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
    s4_exp = '{3'b010, 3'b100, 3'b001, 3'b001};
`else
    s2_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    s4_exp = '{3'b010, 3'b100, 3'b001, 3'b010};
`endif

    // Reset with requests pending: nothing may be granted.
    cycle(3'b111, '0, 1'b1, 1'b0, got);
    cycle(3'b111, '0, 1'b1, 1'b0, got);
    check_val("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_val("reset_rsp_id", 32'(rsp_id), 32'd0);

    // Scenario 1: single read, one-cycle latency.
    rf_mem[5] = 16'hBEEF;
    cycle(3'b001, 12'h005, 1'b0, 1'b1, got);
    check_val("s1_grant", 32'(got), 32'b001);
    check_val("s1_valid", 32'(rsp_valid), 32'd1);
    check_val("s1_id", 32'(rsp_id), 32'd0);
    check_val("s1_data", 32'(rsp_data), 32'hBEEF);

    // Scenario 3: stalled output holds despite register-file change.
    rf_mem[5] = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      cycle(3'b001, 12'h005, 1'b0, 1'b1, got);
      check_val("s3_no_grant", 32'(got), 32'd0);
      check_val("s3_hold", 32'(rsp_data), 32'hBEEF);
    end
    cycle(3'b000, '0, 1'b1, 1'b1, got);

    // Scenario 2: full-throughput arbitration from a fresh pointer.
    cycle(3'b000, '0, 1'b1, 1'b0, got);
    for (int i = 0; i < 6; i++) begin
      cycle(3'b111, 12'h321, 1'b1, 1'b1, got);
      check_val("s2_grant", 32'(got), 32'(s2_exp[i]));
    end

    // Scenario 4: pointer wrap (req1 moves the pointer to 2 first).
    cycle(3'b000, '0, 1'b1, 1'b0, got);
    cycle(3'b010, 12'h0A0, 1'b1, 1'b1, got);
    check_val("s4_grant0", 32'(got), 32'(s4_exp[0]));
    cycle(3'b100, 12'hB00, 1'b1, 1'b1, got);
    check_val("s4_grant1", 32'(got), 32'(s4_exp[1]));
    cycle(3'b011, 12'h0CD, 1'b1, 1'b1, got);
    check_val("s4_grant2", 32'(got), 32'(s4_exp[2]));
    cycle(3'b011, 12'h0CD, 1'b1, 1'b1, got);
    check_val("s4_grant3", 32'(got), 32'(s4_exp[3]));

    // Scenario 5: reset while FULL discards the response.
    cycle(3'b100, 12'h700, 1'b0, 1'b1, got);
    cycle(3'b100, 12'h700, 1'b0, 1'b0, got);
    check_val("s5_valid", 32'(rsp_valid), 32'd0);
    check_val("s5_data", 32'(rsp_data), 32'd0);
    check_val("s5_id", 32'(rsp_id), 32'd0);
    cycle(3'b111, 12'h123, 1'b1, 1'b1, got);
    check_val("s5_ptr_zero", 32'(got), 32'b001);

    // Scenario 6: boundary register indices.
    v15 = 16'($urandom) | 16'h8001;
    v0  = 16'($urandom) & 16'h7FFE;
    rf_mem[15] = v15;
    rf_mem[0]  = v0;
    cycle(3'b000, '0, 1'b1, 1'b1, got);
    cycle(3'b001, 12'h00F, 1'b1, 1'b1, got);
    check_val("s6_idx15", 32'(rsp_data), 32'(v15));
    cycle(3'b010, 12'h000, 1'b1, 1'b1, got);
    check_val("s6_idx0", 32'(rsp_data), 32'(v0));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rf_mem[$urandom_range(0, NR-1)] = 16'($urandom);
      cycle(N'($urandom), 12'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 49) != 0), got);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
